unidad_logica_secuencial: RTL and testbench

- Registered, handshaked responder for the logic-unit operand/result interface: accepts operand pair plus ALUControl, returns result with flags.
- Bitwise ops complete in one cycle; shifts are iterative, 1 bit per cycle.
- Sits between the ALU operand sequencer and the ALU result mux; replaces the purely combinational path where timing on wide shifts is critical.

---
 rtl/unidad_logica_secuencial.sv | 115 +++++++++++
 tb/tb_unidad_logica_secuencial.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_logica_secuencial.sv
// Handshaked logic unit: bitwise ops in one cycle,
// shifts iterated one bit per cycle.
module unidad_logica_secuencial #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] numero1,
    input  logic [N-1:0] numero2,
    input  logic [2:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] resultado,
    output logic         zero,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [N:0] NW = (N+1)'(N);

    state_t        state, state_n;
    logic [N-1:0]  work;
    logic [CW-1:0] cnt;
    logic [2:0]    op;
    logic          accept;
    logic          is_shift;
    logic          b_zero;
    logic          b_big;
    logic          go_shift;
    logic          last;
    logic [N-1:0]  imm;
    logic [N-1:0]  step;

    assign accept   = in_valid && in_ready;
    assign is_shift = ALUControl inside {3'b100, 3'b101, 3'b110};
    assign b_zero   = (numero2 == '0);
    assign b_big    = ({1'b0, numero2} >= NW);
    assign go_shift = is_shift && !b_zero && !b_big;
    assign last     = (cnt == CW'(1));

    // Result when the op completes at the accept edge
    always_comb begin
        imm = '0;
        unique case (ALUControl)
            3'b000:         imm = numero1 & numero2;
            3'b001:         imm = numero1 | numero2;
            3'b010:         imm = numero1 ^ numero2;
            3'b011:         imm = ~numero1;
            3'b100, 3'b101: imm = b_zero ? numero1 : '0;
            3'b110:         imm = b_zero ? numero1 : {N{numero1[N-1]}};
            default:        imm = '0;
        endcase
    end

    always_comb begin
        unique case (op)
            3'b100:  step = {work[N-2:0], 1'b0};
            3'b110:  step = {work[N-1], work[N-1:1]};
            default: step = {1'b0, work[N-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = go_shift ? SHIFT : DONE;
            SHIFT:   if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // resultado/zero/err only change when a new result is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            cnt       <= '0;
            op        <= '0;
            resultado <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            op <= ALUControl;
            if (go_shift) begin
                work <= numero1;
                cnt  <= CW'(numero2);
            end else begin
                resultado <= imm;
                zero      <= (imm == '0);
                err       <= (ALUControl == 3'b111);
            end
        end else if (state == SHIFT) begin
            work <= step;
            cnt  <= cnt - CW'(1);
            if (last) begin
                resultado <= step;
                zero      <= (step == '0);
                err       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_unidad_logica_secuencial.sv
// Bench for unidad_logica_secuencial: directed plan
// plus random traffic against a cycle-level model.
module tb_unidad_logica_secuencial;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] numero1 = '0;
    logic [N-1:0] numero2 = '0;
    logic [2:0]   ALUControl = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] resultado;
    logic         zero;
    logic         err;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    unidad_logica_secuencial #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .numero1(numero1),
        .numero2(numero2),
        .ALUControl(ALUControl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .resultado(resultado),
        .zero(zero),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_res(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [2:0] o);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return a << b;
            3'd5: return a >> b;
            3'd6: return $unsigned($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    // Cycles spent shifting beyond the one-cycle base latency
    function automatic int ref_extra(input logic [7:0] b,
                                     input logic [2:0] o);
        if (o >= 3'd4 && o <= 3'd6 && b != 0 && int'(b) < N)
            return int'(b);
        return 0;
    endfunction

    // Model: busy/valid flags, result appears m_done edges in
    int           m_cyc = 0;
    int           m_done = 0;
    bit           m_busy = 0;
    bit           m_valid = 0;
    logic [7:0]   m_res = '0;
    logic [7:0]   m_pend = '0;
    logic         m_zero = 0;
    logic         m_err = 0;
    logic         m_perr = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_valid = 0;
            m_res = '0; m_zero = 0; m_err = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_pend = ref_res(numero1, numero2, ALUControl);
                m_perr = (ALUControl == 3'd7);
                m_done = m_cyc + ref_extra(numero2, ALUControl);
                if (m_done == m_cyc) begin
                    m_valid = 1; m_res = m_pend;
                    m_zero = (m_pend == 0); m_err = m_perr;
                end
            end
        end else if (!m_valid) begin
            if (m_cyc == m_done) begin
                m_valid = 1; m_res = m_pend;
                m_zero = (m_pend == 0); m_err = m_perr;
            end
        end else if (out_ready) begin
            m_busy = 0; m_valid = 0;
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (run) begin
            chk1("model in_ready", in_ready, !m_busy);
            chk1("model out_valid", out_valid, m_valid);
            if (!(m_busy && !m_valid)) begin
                chk8("model resultado", resultado, m_res);
                chk1("model zero", zero, m_zero);
                chk1("model err", err, m_err);
            end
        end
    end

    task automatic do_op(input string name, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] o,
                         input logic [7:0] exp, input int lat);
        int n;
        numero1 = a; numero2 = b; ALUControl = o;
        out_ready = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk1({name, " ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            chk1({name, " busy in_ready"}, in_ready, 1'b0);
            @(posedge clk); #1; n++;
        end
        chki({name, " latency"}, n, lat);
        chk8({name, " res"}, resultado, exp);
        chk1({name, " zero"}, zero, exp == 8'h00);
        chk1({name, " err"}, err, o == 3'd7);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b1;
        chk1("reset in_ready", in_ready, 1'b1);
        chk1("reset out_valid", out_valid, 1'b0);
        chk8("reset res", resultado, 8'h00);
        chk1("reset zero", zero, 1'b0);
        chk1("reset err", err, 1'b0);

        do_op("and", 8'b11100101, 8'b10101011, 3'd0, 8'b10100001, 1);
        do_op("or",  8'b11100101, 8'b10101011, 3'd1, 8'b11101111, 1);
        do_op("xor", 8'b11100101, 8'b10101011, 3'd2, 8'b01001110, 1);
        do_op("not", 8'b11100101, 8'b10101011, 3'd3, 8'b00011010, 1);
        do_op("sll3", 8'b11100101, 8'd3, 3'd4, 8'b00101000, 4);
        do_op("srl3", 8'b11100101, 8'd3, 3'd5, 8'b00011100, 4);
        do_op("sra3", 8'b11100101, 8'd3, 3'd6, 8'b11111100, 4);
        do_op("sllbig", 8'b11100101, 8'b10101011, 3'd4, 8'h00, 1);
        do_op("srabig", 8'b11100101, 8'b10101011, 3'd6, 8'hff, 1);
        do_op("rsvd", 8'b11100101, 8'b10101011, 3'd7, 8'h00, 1);
        do_op("clrerr", 8'b11100101, 8'b10101011, 3'd0, 8'b10100001, 1);

        // Backpressure with ignored requests
        out_ready = 1'b0;
        numero1 = 8'b11100101; numero2 = 8'b10101011;
        ALUControl = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("bp out_valid", out_valid, 1'b1);
            chk1("bp in_ready", in_ready, 1'b0);
            chk8("bp res", resultado, 8'b11101111);
            numero1 = 8'h00; ALUControl = 3'd0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk1("bp final valid", out_valid, 1'b1);
        @(posedge clk); #1;
        chk1("bp after valid", out_valid, 1'b0);
        chk1("bp after ready", in_ready, 1'b1);
        chk8("bp kept res", resultado, 8'b11101111);

        // Reset on the third shift cycle
        numero1 = 8'b11100101; numero2 = 8'd7;
        ALUControl = 3'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk1("rst mid busy", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("rst out_valid", out_valid, 1'b0);
        chk1("rst in_ready", in_ready, 1'b1);
        chk8("rst res", resultado, 8'h00);
        repeat (10) begin
            @(posedge clk); #1;
            chk1("rst no pulse", out_valid, 1'b0);
        end
        do_op("fresh", 8'b11100101, 8'b10101011, 3'd0, 8'b10100001, 1);
        do_op("srl0", 8'b10000001, 8'd0, 3'd5, 8'b10000001, 1);

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            numero1    = 8'($urandom);
            numero2    = ($urandom_range(0, 3) == 0) ?
                         8'($urandom) : 8'($urandom_range(0, 9));
            ALUControl = 3'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
